seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Parametrised successor to the team's 4-bit load/rotate/arithmetic-shift register.
- Holds a WIDTH-bit register with active-low parallel load and seven shift modes.
- Runs a multi-bit shift one bit per clock under a start/busy/done handshake.
- Used as the datapath shifter in the lab ALU/serial-link exercises; the controller issues a command and waits for done.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- COUNT_W, 4, width of the shift-amount field; amounts 0..2^COUNT_W-1 are legal, including amounts >= WIDTH.

Ports:
- clock  in  1  single rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- ParallelLoadn  in  1  active-low parallel load of Data_IN.
- Data_IN  in  WIDTH  parallel load data.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  3  shift mode; latched at start.
- amount  in  COUNT_W  number of 1-bit steps; latched at start.
- serial_in  in  1  fill bit for the serial modes.
- Q  out  WIDTH  register contents.
- carry_out  out  1  last bit shifted or rotated out.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset (resetn=0, asynchronous, any state): Q=0, carry_out=0, state=IDLE, busy=0, done=0, internal count=0. Outputs change immediately, not at the next edge. Release is synchronous to the next clock edge.
- States: IDLE, SHIFT, DONE. Outputs are registered or decoded from state: busy = (state != IDLE), done = (state == DONE).
- IDLE, ParallelLoadn=0:
  - Q <= Data_IN, carry_out <= 0.
  - Load has priority over start; start in the same cycle is dropped.
- IDLE, start=1 and ParallelLoadn=1:
  - Latch mode and amount; count <= amount.
  - amount != 0 -> SHIFT. amount == 0 -> DONE directly; Q and carry_out unchanged.
  - No shift occurs on the accepting edge.
- SHIFT: each edge performs exactly one step, and count <= count-1. When count == 1 on that edge, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge E; shifts at edges E+1 .. E+amount; done high during the cycle after edge E+amount; IDLE again after edge E+amount+1. For amount=0, done is high in the cycle after E.
- While busy: start and ParallelLoadn are ignored, not queued. Latched mode and amount are immune to input changes.
- Step per mode (c = carry_out after the step):
  - 000 ROL: Q <= {Q[W-2:0], Q[W-1]}, c = Q[W-1].
  - 001 ROR: Q <= {Q[0], Q[W-1:1]}, c = Q[0].
  - 010 LSL: Q <= {Q[W-2:0], 0}, c = Q[W-1].
  - 011 LSR: Q <= {0, Q[W-1:1]}, c = Q[0].
  - 100 ASR: Q <= {Q[W-1], Q[W-1:1]}, c = Q[0].
  - 101 SSL: Q <= {Q[W-2:0], serial_in}, c = Q[W-1]; serial_in sampled each step.
  - 110 SSR: Q <= {serial_in, Q[W-1:1]}, c = Q[0].
  - 111 reserved: Q and c hold, but the step count and timing are identical to the other modes.
- Amounts >= WIDTH need no special casing:
  - Rotates wrap naturally.
  - LSL/LSR reach 0.
  - ASR saturates to all sign bits.

Decomposition:
- Package seq_shift_pkg holds:
  - mode encodings MODE_ROL .. MODE_RSVD (3-bit constants);
  - state encoding for IDLE/SHIFT/DONE.
- One natural sub-module, shift_step: combinational, parametrised by WIDTH. Inputs Q, mode, serial_in; outputs next Q and carry. The top holds the FSM, counter and registers.

Test Plan (WIDTH=8, COUNT_W=4):
- Load 0x96, then start ROR amount=1 -> Q=0x4B, carry_out=0, done pulses exactly 2 cycles after the start edge.
- Load 0x96, ASR amount=3 -> Q steps CB, E5, F2; final carry_out=1; busy high for 4 cycles.
- Load 0xA5, ROL amount=8 -> Q=0xA5, carry_out=1, done in the cycle after edge E+8. Load 0xFF, LSL amount=9 -> Q=0x00, carry_out=0.
- Load 0x00, SSL amount=4 with serial_in=1 -> Q=0x0F. Then amount=0 in any mode -> Q unchanged, done in the cycle right after the start edge.
- During SHIFT, pulse start with new mode/amount and drive ParallelLoadn=0 -> both ignored; original result delivered; no second done.
- Drop resetn mid-SHIFT (between edges) -> Q=0, busy=0, done=0 immediately. After release, start ROR 1 -> completes normally with Q=0.

Source files
------------

// File: rtl/seq_shift_pkg.sv
// Shared encodings for the sequential shift unit: shift modes and FSM states.
package seq_shift_pkg;

    localparam logic [2:0] MODE_ROL  = 3'd0;
    localparam logic [2:0] MODE_ROR  = 3'd1;
    localparam logic [2:0] MODE_LSL  = 3'd2;
    localparam logic [2:0] MODE_LSR  = 3'd3;
    localparam logic [2:0] MODE_ASR  = 3'd4;
    localparam logic [2:0] MODE_SSL  = 3'd5;
    localparam logic [2:0] MODE_SSR  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: combinational next value and carry for a given mode.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_mode,
    input  logic             i_serial_in,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry
);

    always_comb begin
        o_q     = i_q;
        o_carry = i_carry;
        case (i_mode)
            MODE_ROL: begin
                o_q     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_carry = i_q[WIDTH-1];
            end
            MODE_ROR: begin
                o_q     = {i_q[0], i_q[WIDTH-1:1]};
                o_carry = i_q[0];
            end
            MODE_LSL: begin
                o_q     = {i_q[WIDTH-2:0], 1'b0};
                o_carry = i_q[WIDTH-1];
            end
            MODE_LSR: begin
                o_q     = {1'b0, i_q[WIDTH-1:1]};
                o_carry = i_q[0];
            end
            MODE_ASR: begin
                o_q     = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
                o_carry = i_q[0];
            end
            MODE_SSL: begin
                o_q     = {i_q[WIDTH-2:0], i_serial_in};
                o_carry = i_q[WIDTH-1];
            end
            MODE_SSR: begin
                o_q     = {i_serial_in, i_q[WIDTH-1:1]};
                o_carry = i_q[0];
            end
            default: begin
                // Reserved mode still consumes a step slot but leaves state untouched.
                o_q     = i_q;
                o_carry = i_carry;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// WIDTH-bit load/shift register that runs a multi-bit shift one bit per clock
// under a start/busy/done handshake.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               ParallelLoadn,
    input  logic [WIDTH-1:0]   Data_IN,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [COUNT_W-1:0] amount,
    input  logic               serial_in,
    output logic [WIDTH-1:0]   Q,
    output logic               carry_out,
    output logic               busy,
    output logic               done
);

    localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_q;
    logic               r_carry;
    logic [COUNT_W-1:0] r_count;
    logic [2:0]         r_mode;
    logic [WIDTH-1:0]   w_q_step;
    logic               w_carry_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q         (r_q),
        .i_mode      (r_mode),
        .i_serial_in (serial_in),
        .i_carry     (r_carry),
        .o_q         (w_q_step),
        .o_carry     (w_carry_step)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Load wins over start; a dropped start never leaves IDLE.
                if (ParallelLoadn && start) begin
                    w_state_next = (amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_count == ONE) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_mode  <= MODE_ROL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!ParallelLoadn) begin
                        r_q     <= Data_IN;
                        r_carry <= 1'b0;
                    end else if (start) begin
                        r_mode  <= mode;
                        r_count <= amount;
                    end
                end
                ST_SHIFT: begin
                    r_q     <= w_q_step;
                    r_carry <= w_carry_step;
                    r_count <= r_count - ONE;
                end
                default: ;
            endcase
        end
    end

    assign Q         = r_q;
    assign carry_out = r_carry;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=8, COUNT_W=4); expected values are hand-computed.
module tb_seq_shift_unit;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       ParallelLoadn = 1'b1;
    logic [7:0] Data_IN = '0;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] amount = '0;
    logic       serial_in = 1'b0;
    logic [7:0] Q;
    logic       carry_out;
    logic       busy;
    logic       done;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    seq_shift_unit #(
        .WIDTH   (8),
        .COUNT_W (4)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .ParallelLoadn (ParallelLoadn),
        .Data_IN       (Data_IN),
        .start         (start),
        .mode          (mode),
        .amount        (amount),
        .serial_in     (serial_in),
        .Q             (Q),
        .carry_out     (carry_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        ParallelLoadn = 1'b0;
        Data_IN = v;
        tick();
        ParallelLoadn = 1'b1;
    endtask

    task automatic issue(input logic [2:0] m, input logic [3:0] a);
        start = 1'b1;
        mode = m;
        amount = a;
        tick();
        start = 1'b0;
    endtask

    // Observed vector layout: {Q, carry_out, busy, done}
    task automatic test_reset();
        #1 resetn = 1'b0;
        #2;
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_async: got %h/%b%b%b required 00/000", Q, carry_out, busy, done);
        end
        tick();
        tick();
        resetn = 1'b1;
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_release: got %h/%b%b%b required 00/000", Q, carry_out, busy, done);
        end
    endtask

    task automatic test_ror();
        load(8'h96);
        issue(3'd1, 4'd1);
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h96, 3'b010}) begin
            miscompares++;
            $display("FAIL ror_accept: got %h/%b%b%b required 96/010", Q, carry_out, busy, done);
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h4B, 3'b011}) begin
            miscompares++;
            $display("FAIL ror_done: got %h/%b%b%b required 4b/011", Q, carry_out, busy, done);
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h4B, 3'b000}) begin
            miscompares++;
            $display("FAIL ror_idle: got %h/%b%b%b required 4b/000", Q, carry_out, busy, done);
        end
    endtask

    task automatic test_asr();
        logic [7:0] exp_q [4] = '{8'hCB, 8'hE5, 8'hF2, 8'hF2};
        logic [2:0] exp_f [4] = '{3'b010, 3'b110, 3'b111, 3'b100};
        load(8'h96);
        issue(3'd4, 4'd3);
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h96, 3'b010}) begin
            miscompares++;
            $display("FAIL asr_accept: got %h/%b%b%b required 96/010", Q, carry_out, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({Q, carry_out, busy, done} !== {exp_q[i], exp_f[i]}) begin
                miscompares++;
                $display("FAIL asr_step%0d: got %h/%b%b%b required %h/%b", i + 1, Q, carry_out, busy, done, exp_q[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_wide_amounts();
        load(8'hA5);
        issue(3'd0, 4'd8);
        for (int i = 1; i < 8; i++) begin
            tick();
            vectors++;
            if ({busy, done} !== 2'b10) begin
                miscompares++;
                $display("FAIL rol8_busy%0d: got busy/done %b%b required 10", i, busy, done);
            end
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'hA5, 3'b111}) begin
            miscompares++;
            $display("FAIL rol8_done: got %h/%b%b%b required a5/111", Q, carry_out, busy, done);
        end
        tick();
        load(8'hFF);
        issue(3'd2, 4'd9);
        repeat (8) tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b110}) begin
            miscompares++;
            $display("FAIL lsl9_step8: got %h/%b%b%b required 00/110", Q, carry_out, busy, done);
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b011}) begin
            miscompares++;
            $display("FAIL lsl9_done: got %h/%b%b%b required 00/011", Q, carry_out, busy, done);
        end
        tick();
    endtask

    task automatic test_ssl_and_zero();
        load(8'h00);
        serial_in = 1'b1;
        issue(3'd5, 4'd4);
        repeat (3) tick();
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h0F, 3'b011}) begin
            miscompares++;
            $display("FAIL ssl4_done: got %h/%b%b%b required 0f/011", Q, carry_out, busy, done);
        end
        tick();
        serial_in = 1'b0;
        issue(3'd6, 4'd0);
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h0F, 3'b011}) begin
            miscompares++;
            $display("FAIL zero_done: got %h/%b%b%b required 0f/011", Q, carry_out, busy, done);
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h0F, 3'b000}) begin
            miscompares++;
            $display("FAIL zero_idle: got %h/%b%b%b required 0f/000", Q, carry_out, busy, done);
        end
    endtask

    task automatic test_reserved();
        load(8'h3C);
        issue(3'd7, 4'd2);
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h3C, 3'b010}) begin
            miscompares++;
            $display("FAIL rsvd_step1: got %h/%b%b%b required 3c/010", Q, carry_out, busy, done);
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h3C, 3'b011}) begin
            miscompares++;
            $display("FAIL rsvd_done: got %h/%b%b%b required 3c/011", Q, carry_out, busy, done);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp_q [3] = '{8'h40, 8'h20, 8'h10};
        logic [2:0] exp_f [3] = '{3'b110, 3'b010, 3'b011};
        load(8'h81);
        issue(3'd3, 4'd3);
        start = 1'b1;
        mode = 3'd0;
        amount = 4'd1;
        ParallelLoadn = 1'b0;
        Data_IN = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({Q, carry_out, busy, done} !== {exp_q[i], exp_f[i]}) begin
                miscompares++;
                $display("FAIL busy_ign_step%0d: got %h/%b%b%b required %h/%b", i + 1, Q, carry_out, busy, done, exp_q[i], exp_f[i]);
            end
        end
        start = 1'b0;
        ParallelLoadn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({Q, carry_out, busy, done} !== {8'h10, 3'b000}) begin
                miscompares++;
                $display("FAIL busy_ign_after%0d: got %h/%b%b%b required 10/000", i, Q, carry_out, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        load(8'hF0);
        issue(3'd1, 4'd5);
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h78, 3'b010}) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got %h/%b%b%b required 78/010", Q, carry_out, busy, done);
        end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %h/%b%b%b required 00/000", Q, carry_out, busy, done);
        end
        #3 resetn = 1'b1;
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            miscompares++;
            $display("FAIL rst_mid_idle: got %h/%b%b%b required 00/000", Q, carry_out, busy, done);
        end
        issue(3'd1, 4'd1);
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b011}) begin
            miscompares++;
            $display("FAIL rst_mid_ror_done: got %h/%b%b%b required 00/011", Q, carry_out, busy, done);
        end
        tick();
        vectors++;
        if ({Q, carry_out, busy, done} !== {8'h00, 3'b000}) begin
            miscompares++;
            $display("FAIL rst_mid_ror_idle: got %h/%b%b%b required 00/000", Q, carry_out, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_ror();
        test_asr();
        test_wide_amounts();
        test_ssl_and_zero();
        test_reserved();
        test_busy_ignore();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
